// File: rtl/axil_master_initiator.sv
// Single-outstanding AXI4-Lite master: turns a valid/ready command stream into
// AW/W/B or AR/R transactions and returns one response per command, with a watchdog.
module axil_master_initiator #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic                  clk_main_a0,
    input  logic                  rst_main,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,

    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    input  logic [1:0]            m_bresp,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [ADDR_W-1:0]     m_araddr,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic [1:0]            m_rresp
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_RESP,
        RSP,
        DRAIN
    } state_t;

    localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t              state_reg;
    logic                req_ready_reg;
    logic                awvalid_reg;
    logic                wvalid_reg;
    logic                arvalid_reg;
    logic                bready_reg;
    logic                rready_reg;
    logic                rsp_valid_reg;
    logic [DATA_W-1:0]   rsp_rdata_reg;
    logic [1:0]          rsp_resp_reg;
    logic                rsp_timeout_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [DATA_W/8-1:0] wstrb_reg;
    logic                is_write_reg;
    logic                aw_done_reg;
    logic                w_done_reg;
    logic                ar_done_reg;
    logic                resp_done_reg;
    logic [CNT_W-1:0]    cnt_reg;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_fin, w_fin, ar_fin, resp_fin;
    logic active, expire, chans_fin, rsp_clear, drain_done;

    assign aw_hs = awvalid_reg & m_awready;
    assign w_hs  = wvalid_reg  & m_wready;
    assign b_hs  = bready_reg  & m_bvalid;
    assign ar_hs = arvalid_reg & m_arready;
    assign r_hs  = rready_reg  & m_rvalid;

    // "fin" flags include a handshake happening in the current cycle
    assign aw_fin   = aw_done_reg | aw_hs;
    assign w_fin    = w_done_reg  | w_hs;
    assign ar_fin   = ar_done_reg | ar_hs;
    assign resp_fin = resp_done_reg | b_hs | r_hs;

    assign active = (state_reg == WR_ADDR_DATA) || (state_reg == WR_RESP) ||
                    (state_reg == RD_ADDR)      || (state_reg == RD_RESP);
    assign expire = TO_EN && active && (cnt_reg == TO_LAST);

    assign chans_fin  = is_write_reg ? (aw_fin && w_fin && resp_fin) : (ar_fin && resp_fin);
    assign rsp_clear  = !rsp_valid_reg || rsp_ready;
    assign drain_done = chans_fin && rsp_clear;

    assign req_ready   = req_ready_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign rsp_resp    = rsp_resp_reg;
    assign rsp_timeout = rsp_timeout_reg;
    assign m_awvalid   = awvalid_reg;
    assign m_awaddr    = addr_reg;
    assign m_wvalid    = wvalid_reg;
    assign m_wdata     = wdata_reg;
    assign m_wstrb     = wstrb_reg;
    assign m_bready    = bready_reg;
    assign m_arvalid   = arvalid_reg;
    assign m_araddr    = addr_reg;
    assign m_rready    = rready_reg;

    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            state_reg       <= IDLE;
            req_ready_reg   <= 1'b0;
            awvalid_reg     <= 1'b0;
            wvalid_reg      <= 1'b0;
            arvalid_reg     <= 1'b0;
            bready_reg      <= 1'b0;
            rready_reg      <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_resp_reg    <= 2'b00;
            rsp_timeout_reg <= 1'b0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            wstrb_reg       <= '0;
            is_write_reg    <= 1'b0;
            aw_done_reg     <= 1'b0;
            w_done_reg      <= 1'b0;
            ar_done_reg     <= 1'b0;
            resp_done_reg   <= 1'b0;
            cnt_reg         <= '0;
        end else begin
            // Channel bookkeeping is state-independent so DRAIN can track stragglers
            if (aw_hs) begin
                awvalid_reg <= 1'b0;
                aw_done_reg <= 1'b1;
            end
            if (w_hs) begin
                wvalid_reg <= 1'b0;
                w_done_reg <= 1'b1;
            end
            if (ar_hs) begin
                arvalid_reg <= 1'b0;
                ar_done_reg <= 1'b1;
            end
            if (b_hs || r_hs) begin
                resp_done_reg <= 1'b1;
            end
            if (active && (cnt_reg != CNT_MAX)) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end

            case (state_reg)
                IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (req_valid && req_ready_reg) begin
                        req_ready_reg <= 1'b0;
                        addr_reg      <= req_addr;
                        wdata_reg     <= req_wdata;
                        wstrb_reg     <= req_wstrb;
                        is_write_reg  <= req_write;
                        cnt_reg       <= '0;
                        aw_done_reg   <= 1'b0;
                        w_done_reg    <= 1'b0;
                        ar_done_reg   <= 1'b0;
                        resp_done_reg <= 1'b0;
                        if (req_write) begin
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                            state_reg   <= WR_ADDR_DATA;
                        end else begin
                            arvalid_reg <= 1'b1;
                            state_reg   <= RD_ADDR;
                        end
                    end
                end

                WR_ADDR_DATA: begin
                    if (expire) begin
                        rsp_valid_reg   <= 1'b1;
                        rsp_resp_reg    <= 2'b11;
                        rsp_rdata_reg   <= '0;
                        rsp_timeout_reg <= 1'b1;
                        bready_reg      <= 1'b1;
                        state_reg       <= DRAIN;
                    end else if (aw_fin && w_fin) begin
                        bready_reg <= 1'b1;
                        state_reg  <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    // A response landing on the expiry cycle beats the timeout
                    if (b_hs) begin
                        bready_reg      <= 1'b0;
                        rsp_valid_reg   <= 1'b1;
                        rsp_resp_reg    <= m_bresp;
                        rsp_rdata_reg   <= '0;
                        rsp_timeout_reg <= 1'b0;
                        state_reg       <= RSP;
                    end else if (expire) begin
                        rsp_valid_reg   <= 1'b1;
                        rsp_resp_reg    <= 2'b11;
                        rsp_rdata_reg   <= '0;
                        rsp_timeout_reg <= 1'b1;
                        state_reg       <= DRAIN;
                    end
                end

                RD_ADDR: begin
                    if (expire) begin
                        rsp_valid_reg   <= 1'b1;
                        rsp_resp_reg    <= 2'b11;
                        rsp_rdata_reg   <= '0;
                        rsp_timeout_reg <= 1'b1;
                        rready_reg      <= 1'b1;
                        state_reg       <= DRAIN;
                    end else if (ar_hs) begin
                        rready_reg <= 1'b1;
                        state_reg  <= RD_RESP;
                    end
                end

                RD_RESP: begin
                    if (r_hs) begin
                        rready_reg      <= 1'b0;
                        rsp_valid_reg   <= 1'b1;
                        rsp_resp_reg    <= m_rresp;
                        rsp_rdata_reg   <= m_rdata;
                        rsp_timeout_reg <= 1'b0;
                        state_reg       <= RSP;
                    end else if (expire) begin
                        rsp_valid_reg   <= 1'b1;
                        rsp_resp_reg    <= 2'b11;
                        rsp_rdata_reg   <= '0;
                        rsp_timeout_reg <= 1'b1;
                        state_reg       <= DRAIN;
                    end
                end

                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end

                DRAIN: begin
                    // Late B/R beats are swallowed; only the timeout response is reported
                    if (rsp_valid_reg && rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                    end
                    if (b_hs) begin
                        bready_reg <= 1'b0;
                    end
                    if (r_hs) begin
                        rready_reg <= 1'b0;
                    end
                    if (drain_done) begin
                        bready_reg    <= 1'b0;
                        rready_reg    <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/axil_master_initiator.md
Name: axil_master_initiator

Overview:
- Single-outstanding AXI4-Lite master. Converts a simple valid/ready command stream from user logic into AXI-Lite write (AW/W/B) or read (AR/R) transactions.
- Returns one response per command on a valid/ready response stream.
- Acts as the initiator side of the management/SDA AXI-Lite register bus. It drives register slaves inside mkAwsF1Top-style designs and their standalone benches.
- Includes a response timeout, so a hung slave cannot stall user logic.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (fixed 32; strobe width DATA_W/8).
- TIMEOUT_CYCLES, 1024, cycles allowed from command accept to B/R handshake; 0 disables the timeout.
- CNT_W, 16, timeout counter width; must satisfy TIMEOUT_CYCLES < 2**CNT_W.

Ports:
- clk_main_a0  in  1  sole clock; all logic rising-edge.
- rst_main  in  1  asynchronous, active-high reset.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when req_valid&req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_wstrb  in  DATA_W/8  write strobes.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data (0 for writes/timeouts).
- rsp_resp  out  2  AXI BRESP/RRESP, or 2'b11 on timeout.
- rsp_timeout  out  1  response was generated by the timeout.
- m_awvalid/m_awready/m_awaddr, m_wvalid/m_wready/m_wdata/m_wstrb, m_bvalid/m_bready/m_bresp, m_arvalid/m_arready/m_araddr, m_rvalid/m_rready/m_rdata/m_rresp  standard AXI-Lite master directions and widths.

Behaviour:
- Reset (async assert, sync deassert use of clk): state=IDLE. All m_*valid, m_bready, m_rready, rsp_valid, rsp_timeout = 0. rsp_rdata=0, rsp_resp=0, timeout counter=0.
- req_ready = 1 only in IDLE, registered-state decode; no combinational path from req_valid.
- States:
  - IDLE
  - WR_ADDR_DATA
  - WR_RESP
  - RD_ADDR
  - RD_RESP
  - RSP
  - DRAIN
- IDLE: on req handshake (cycle N), latch addr/data/strb. If write, go to WR_ADDR_DATA with m_awvalid=m_wvalid=1 from N+1. If read, go to RD_RADDR with m_arvalid=1 from N+1. Clear the counter.
- WR_ADDR_DATA: AW and W complete independently. Each valid drops the cycle after its own handshake. Go to WR_RESP when both are done; if both complete in the same cycle, go directly.
- m_bready = 1 in WR_RESP. m_rready = 1 in RD_RESP. m_bready/m_rready are 0 in all other states except DRAIN.
- RD_ADDR: m_arvalid held until m_arready; then go to RD_RESP.
- B or R handshake at cycle M: capture resp (and rdata for reads). rsp_valid=1 from M+1; go to RSP.
- RSP: hold rsp_* stable while rsp_valid & !rsp_ready. On handshake, rsp_valid=0 next cycle and go to IDLE. Minimum accept-to-accept period is 4 cycles for a zero-wait slave.
- AXI rule: no valid deasserts before its ready. Address and data outputs are stable while valid is high.
- Timeout: the counter increments every cycle in WR_ADDR_DATA/WR_RESP/RD_ADDR/RD_RESP, saturating.
  - When it reaches TIMEOUT_CYCLES with no B/R handshake in that cycle: rsp_valid=1, rsp_resp=2'b11, rsp_timeout=1, rsp_rdata=0; go to DRAIN.
  - A handshake in the same cycle as expiry wins: normal response, no timeout.
- DRAIN: pending m_*valid stay asserted until their handshakes complete. m_bready/m_rready held 1 and the late response is discarded.
  - Leave DRAIN for IDLE only when all channels of the transaction have completed and rsp handshake has occurred.
  - rsp_valid is held in DRAIN until rsp_ready.
- Slave SLVERR/DECERR is passed through unchanged, with rsp_timeout=0.
- Reset mid-transaction returns immediately to reset values. The bench must reset the slave as well.

Test Plan:
- Write addr=0x10, data=0xDEADBEEF, strb=0xF. Slave asserts awready at N+1, wready at N+3, bvalid at N+5 with OKAY. Required: awvalid drops at N+2, wvalid drops at N+4, rsp_valid at N+6 with resp=0, timeout=0.
- Read addr=0x20, slave returns rdata=0x12345678, rresp=0 with zero waits. Required: arvalid at N+1, rready at N+2, rsp_valid at N+3, rsp_rdata=0x12345678, req_ready back at N+4 after rsp_ready=1.
- Read where slave returns rresp=2'b10. Required: rsp_resp=2'b10, rsp_timeout=0.
- rsp_ready held 0 for 7 cycles. Required: rsp_* stable, req_ready=0, and a second req_valid is not accepted until 1 cycle after the rsp handshake.
- TIMEOUT_CYCLES=8, slave never asserts bvalid. Required: rsp_valid with resp=2'b11 and rsp_timeout=1 at accept+9. A bvalid injected 20 cycles later is consumed (bready=1) and produces no response; the block then returns to IDLE.
- Assert rst_main while awvalid=1 and awready=0. Required: awvalid=0 and req_ready=0 immediately. After deassertion, req_ready=1 on the next clock.
